// File: rtl/reg_tag_match_unit.sv
// reg_tag_match_unit: tracks the producer tag of each architectural register, matches
// pipe completion tags against it and issues at most one registered writeback per cycle.
module reg_tag_match_unit #(
    parameter int NUM_REGS     = 16,
    parameter int REG_ADDR_W   = 4,
    parameter int TAG_W        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  dispatch_valid_in,
    input  logic [REG_ADDR_W-1:0] dispatch_rd_addr_in,
    input  logic [TAG_W-1:0]      dispatch_tag_in,
    input  logic                  pipe1_valid_in,
    input  logic [TAG_W-1:0]      pipe1_tag_in,
    output logic                  pipe1_ready_out,
    input  logic                  pipe2_valid_in,
    input  logic [TAG_W-1:0]      pipe2_tag_in,
    output logic                  pipe2_ready_out,
    input  logic                  pipe3_valid_in,
    input  logic [TAG_W-1:0]      pipe3_tag_in,
    output logic                  pipe3_ready_out,
    input  logic                  pipe4_valid_in,
    input  logic [TAG_W-1:0]      pipe4_tag_in,
    output logic                  pipe4_ready_out,
    output logic                  tag_matched_with_alu_pipe1_final_out,
    output logic                  tag_matched_with_alu_pipe2_final_out,
    output logic                  tag_matched_with_load_store_pipe3_final_out,
    output logic                  tag_matched_with_branch_pipe4_final_out,
    output logic                  wb_valid_out,
    output logic [REG_ADDR_W-1:0] wb_rd_addr_out,
    output logic [NUM_REGS-1:0]   reg_busy_out
);
    localparam int NP = 4;

    logic [NUM_REGS-1:0]            r_busy;
    logic [NUM_REGS-1:0][TAG_W-1:0] r_tag;
    logic [NP-1:0][2:0]             r_starve;
    logic                           r_wb_valid;
    logic [REG_ADDR_W-1:0]          r_wb_addr;
    logic [NP-1:0]                  r_final;

    logic [NP-1:0]                  w_valid;
    logic [NP-1:0]                  w_hit;
    logic [NP-1:0]                  w_starved;
    logic [NP-1:0]                  w_cand;
    logic [NP-1:0]                  w_grant;
    logic [NP-1:0]                  w_ready;
    logic [NP-1:0][TAG_W-1:0]       w_tag;
    logic [NP-1:0][REG_ADDR_W-1:0]  w_hit_addr;
    logic [REG_ADDR_W-1:0]          w_grant_addr;

    assign w_valid = {pipe4_valid_in, pipe3_valid_in, pipe2_valid_in, pipe1_valid_in};
    assign w_tag   = {pipe4_tag_in, pipe3_tag_in, pipe2_tag_in, pipe1_tag_in};

    // Busy tags are unique, so OR-ing the matching indices yields the single matching register.
    always_comb begin
        w_hit      = '0;
        w_hit_addr = '0;
        for (int p = 0; p < NP; p++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_valid[p] && r_busy[r] && r_tag[r] == w_tag[p]) begin
                    w_hit[p]      = 1'b1;
                    w_hit_addr[p] = w_hit_addr[p] | REG_ADDR_W'(r);
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NP; g++) begin : g_starve
            assign w_starved[g] = r_starve[g] >= 3'(STARVE_LIMIT);
        end
    endgenerate

    // Starved hitters pre-empt base order; lowest set bit is pipe1-first priority.
    assign w_cand  = reset_in ? '0 : (|(w_hit & w_starved) ? (w_hit & w_starved) : w_hit);
    assign w_grant = w_cand & (~w_cand + NP'(1));
    assign w_ready = reset_in ? '0 : (~w_valid | ~w_hit | w_grant);

    always_comb begin
        w_grant_addr = '0;
        for (int p = 0; p < NP; p++)
            if (w_grant[p]) w_grant_addr = w_hit_addr[p];
    end

    always_ff @(posedge clk_in) begin
        for (int p = 0; p < NP; p++) begin
            if (reset_in || !w_valid[p] || w_grant[p])
                r_starve[p] <= '0;
            else if (w_hit[p] && !w_starved[p])
                r_starve[p] <= r_starve[p] + 3'd1;
        end
    end

    // Dispatch is written after the writeback clear so it wins on a same-register collision.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_busy <= '0;
            r_tag  <= '0;
        end else begin
            if (|w_grant)
                r_busy[w_grant_addr] <= 1'b0;
            if (dispatch_valid_in) begin
                r_busy[dispatch_rd_addr_in] <= 1'b1;
                r_tag[dispatch_rd_addr_in]  <= dispatch_tag_in;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_final    <= '0;
        end else begin
            r_wb_valid <= |w_grant;
            r_final    <= w_grant;
            if (|w_grant)
                r_wb_addr <= w_grant_addr;
        end
    end

    assign pipe1_ready_out = w_ready[0];
    assign pipe2_ready_out = w_ready[1];
    assign pipe3_ready_out = w_ready[2];
    assign pipe4_ready_out = w_ready[3];
    assign tag_matched_with_alu_pipe1_final_out        = r_final[0];
    assign tag_matched_with_alu_pipe2_final_out        = r_final[1];
    assign tag_matched_with_load_store_pipe3_final_out = r_final[2];
    assign tag_matched_with_branch_pipe4_final_out     = r_final[3];
    assign wb_valid_out   = r_wb_valid;
    assign wb_rd_addr_out = r_wb_addr;
    assign reg_busy_out   = r_busy;
endmodule

// File: tb/tb_reg_tag_match_unit.sv
// tb_reg_tag_match_unit: directed scenarios plus randomized traffic checked against
// a register-table reference model.
module tb_reg_tag_match_unit;
    localparam int NR = 16;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst;
    logic dv;
    logic [3:0] da, dt;
    logic [3:0] pv;
    logic [3:0][3:0] pt;
    logic [3:0] pr, fin;
    logic wbv;
    logic [3:0] wba;
    logic [15:0] busy;

    always #5 clk = ~clk;

    reg_tag_match_unit dut (
        .clk_in(clk), .reset_in(rst),
        .dispatch_valid_in(dv), .dispatch_rd_addr_in(da), .dispatch_tag_in(dt),
        .pipe1_valid_in(pv[0]), .pipe1_tag_in(pt[0]), .pipe1_ready_out(pr[0]),
        .pipe2_valid_in(pv[1]), .pipe2_tag_in(pt[1]), .pipe2_ready_out(pr[1]),
        .pipe3_valid_in(pv[2]), .pipe3_tag_in(pt[2]), .pipe3_ready_out(pr[2]),
        .pipe4_valid_in(pv[3]), .pipe4_tag_in(pt[3]), .pipe4_ready_out(pr[3]),
        .tag_matched_with_alu_pipe1_final_out(fin[0]),
        .tag_matched_with_alu_pipe2_final_out(fin[1]),
        .tag_matched_with_load_store_pipe3_final_out(fin[2]),
        .tag_matched_with_branch_pipe4_final_out(fin[3]),
        .wb_valid_out(wbv), .wb_rd_addr_out(wba), .reg_busy_out(busy)
    );

    int checks = 0, errors = 0;

    bit       m_busy[NR];
    bit [3:0] m_tag[NR];
    int       m_starve[4];
    bit       m_wbv;
    bit [3:0] m_wba;
    bit [3:0] m_fin;
    bit [3:0] e_ready;
    bit       e_hit[4];
    int       e_reg[4];
    int       e_g;
    logic [3:0] o_ready;

    function automatic logic [15:0] m_busy_vec();
        logic [15:0] v;
        for (int r = 0; r < NR; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_comb();
        int n;
        for (int p = 0; p < 4; p++) begin
            e_hit[p] = 0;
            e_reg[p] = 0;
            n = 0;
            if (pv[p])
                for (int r = 0; r < NR; r++)
                    if (m_busy[r] && m_tag[r] == pt[p]) begin
                        e_hit[p] = 1;
                        e_reg[p] = r;
                        n++;
                    end
            checks++;
            if (n > 1) begin
                errors++;
                $display("FAIL dup_match pipe%0d tag %0d matches %0d entries, required at most 1", p + 1, pt[p], n);
            end
        end
        e_g = -1;
        if (!rst) begin
            for (int p = 0; p < 4; p++)
                if (e_g < 0 && e_hit[p] && m_starve[p] >= SL) e_g = p;
            for (int p = 0; p < 4; p++)
                if (e_g < 0 && e_hit[p]) e_g = p;
        end
        for (int p = 0; p < 4; p++)
            e_ready[p] = !rst && (!pv[p] || !e_hit[p] || p == e_g);
    endtask

    task automatic model_clock();
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_busy[r] = 0;
                m_tag[r] = 0;
            end
            for (int p = 0; p < 4; p++) m_starve[p] = 0;
            m_wbv = 0;
            m_wba = 0;
            m_fin = 0;
        end else begin
            for (int p = 0; p < 4; p++)
                if (!pv[p] || p == e_g) m_starve[p] = 0;
                else if (e_hit[p] && m_starve[p] < SL) m_starve[p]++;
            if (e_g >= 0) begin
                m_wbv = 1;
                m_wba = 4'(e_reg[e_g]);
                m_fin = 4'(1 << e_g);
                m_busy[e_reg[e_g]] = 0;
            end else begin
                m_wbv = 0;
                m_fin = 0;
            end
            if (dv) begin
                m_busy[da] = 1;
                m_tag[da] = dt;
            end
        end
    endtask

    // Ready is sampled mid-cycle, registered outputs 1 time unit after the edge.
    task automatic step();
        @(negedge clk);
        model_comb();
        o_ready = pr;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic disp(input int a, input int t);
        dv = 1; da = 4'(a); dt = 4'(t); pv = 0;
        step();
        dv = 0;
    endtask

    task automatic test_reset();
        rst = 1; dv = 1; da = 4'd2; dt = 4'd9; pv = 4'hF; pt = 16'h1234;
        step();
        step();
        checks++; if (o_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", o_ready); end
        checks++; if (wbv !== 1'b0) begin errors++; $display("FAIL reset_wbv got %b want 0", wbv); end
        checks++; if (fin !== 4'b0000) begin errors++; $display("FAIL reset_final got %b want 0000", fin); end
        checks++; if (wba !== 4'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", wba); end
        checks++; if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy got %h want 0000", busy); end
        rst = 0; dv = 0; pv = 0;
    endtask

    task automatic test_basic();
        disp(3, 5);
        checks++; if (busy !== 16'h0008) begin errors++; $display("FAIL basic_busy_set got %h want 0008", busy); end
        pv = 4'b0010; pt[1] = 4'd5;
        step();
        checks++; if (o_ready !== 4'b1111) begin errors++; $display("FAIL basic_ready got %b want 1111", o_ready); end
        checks++; if (wbv !== 1'b1 || wba !== 4'd3) begin errors++; $display("FAIL basic_wb got v=%b a=%0d want v=1 a=3", wbv, wba); end
        checks++; if (fin !== 4'b0010) begin errors++; $display("FAIL basic_final got %b want 0010", fin); end
        checks++; if (busy[3] !== 1'b0) begin errors++; $display("FAIL basic_busy_clr got %b want 0", busy[3]); end
        pv = 0;
        step();
        checks++; if (wbv !== 1'b0 || fin !== 4'b0000 || wba !== 4'd3) begin errors++; $display("FAIL basic_idle got v=%b f=%b a=%0d want v=0 f=0000 a=3", wbv, fin, wba); end
    endtask

    task automatic test_priority();
        disp(1, 1);
        disp(2, 2);
        pv = 4'b1001; pt[0] = 4'd1; pt[3] = 4'd2;
        step();
        checks++; if (o_ready !== 4'b0111) begin errors++; $display("FAIL prio_ready got %b want 0111", o_ready); end
        checks++; if (fin !== 4'b0001 || wba !== 4'd1) begin errors++; $display("FAIL prio_first got f=%b a=%0d want f=0001 a=1", fin, wba); end
        pv = 4'b1000;
        step();
        checks++; if (o_ready !== 4'b1111) begin errors++; $display("FAIL prio_second_ready got %b want 1111", o_ready); end
        checks++; if (fin !== 4'b1000 || wba !== 4'd2 || wbv !== 1'b1) begin errors++; $display("FAIL prio_second got f=%b a=%0d v=%b want f=1000 a=2 v=1", fin, wba, wbv); end
        pv = 0;
    endtask

    task automatic test_starve();
        int tags[5] = '{4, 6, 7, 8, 12};
        disp(8, 3);
        for (int k = 0; k < 5; k++) disp(9 + k, tags[k]);
        pv = 4'b0101; pt[2] = 4'd3;
        for (int k = 0; k < 5; k++) begin
            pt[0] = 4'(tags[k]);
            step();
            checks++;
            if (o_ready !== (k < 4 ? 4'b1011 : 4'b1110)) begin errors++; $display("FAIL starve_ready k=%0d got %b want %b", k, o_ready, k < 4 ? 4'b1011 : 4'b1110); end
            checks++;
            if (fin !== (k < 4 ? 4'b0001 : 4'b0100) || wba !== (k < 4 ? 4'(9 + k) : 4'd8)) begin
                errors++; $display("FAIL starve_wb k=%0d got f=%b a=%0d want f=%b a=%0d", k, fin, wba, k < 4 ? 4'b0001 : 4'b0100, k < 4 ? 9 + k : 8);
            end
        end
        pv = 4'b0001;
        step();
        checks++; if (fin !== 4'b0001 || wba !== 4'd13) begin errors++; $display("FAIL starve_tail got f=%b a=%0d want f=0001 a=13", fin, wba); end
        pv = 0;
    endtask

    task automatic test_stale();
        disp(7, 9);
        disp(7, 10);
        pv = 4'b0100; pt[2] = 4'd9;
        step();
        checks++; if (o_ready[2] !== 1'b1 || wbv !== 1'b0) begin errors++; $display("FAIL stale_drop got r=%b v=%b want r=1 v=0", o_ready[2], wbv); end
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL stale_busy got %b want 1", busy[7]); end
        pv = 4'b0001; pt[0] = 4'd10;
        step();
        checks++; if (o_ready[0] !== 1'b1 || wbv !== 1'b1 || wba !== 4'd7 || fin !== 4'b0001) begin
            errors++; $display("FAIL stale_new got r=%b v=%b a=%0d f=%b want r=1 v=1 a=7 f=0001", o_ready[0], wbv, wba, fin);
        end
        checks++; if (busy[7] !== 1'b0) begin errors++; $display("FAIL stale_clr got %b want 0", busy[7]); end
        pv = 0;
    endtask

    task automatic test_back_to_back();
        disp(4, 6);
        pv = 4'b0001; pt[0] = 4'd6; dv = 1; da = 4'd4; dt = 4'd11;
        step();
        dv = 0;
        checks++; if (wbv !== 1'b1 || wba !== 4'd4 || busy[4] !== 1'b1) begin errors++; $display("FAIL b2b_wb got v=%b a=%0d busy=%b want v=1 a=4 busy=1", wbv, wba, busy[4]); end
        pv = 4'b0010; pt[1] = 4'd11;
        step();
        checks++; if (fin !== 4'b0010 || wba !== 4'd4 || busy[4] !== 1'b0) begin errors++; $display("FAIL b2b_newtag got f=%b a=%0d busy=%b want f=0010 a=4 busy=0", fin, wba, busy[4]); end
        pv = 0;
    endtask

    task automatic test_reset_mid();
        disp(5, 1);
        disp(6, 2);
        pv = 4'b0011; pt[0] = 4'd1; pt[1] = 4'd2;
        step();
        checks++; if (o_ready !== 4'b1101) begin errors++; $display("FAIL rmid_stall got %b want 1101", o_ready); end
        rst = 1; pv = 4'b0010;
        step();
        checks++; if (o_ready !== 4'b0000) begin errors++; $display("FAIL rmid_ready got %b want 0000", o_ready); end
        checks++; if (wbv !== 1'b0 || fin !== 4'b0000 || wba !== 4'd0 || busy !== 16'h0) begin
            errors++; $display("FAIL rmid_out got v=%b f=%b a=%0d busy=%h want all 0", wbv, fin, wba, busy);
        end
        rst = 0;
        step();
        checks++; if (o_ready !== 4'b1111 || wbv !== 1'b0) begin errors++; $display("FAIL rmid_stale got r=%b v=%b want r=1111 v=0", o_ready, wbv); end
        pv = 0;
    endtask

    task automatic test_random();
        bit [3:0] held = 0;
        for (int c = 0; c < 600; c++) begin
            bit [15:0] claimed;
            int s, t;
            bit found;
            claimed = 0;
            rst = ($urandom_range(0, 59) == 0);
            for (int p = 0; p < 4; p++) if (held[p]) claimed[pt[p]] = 1;
            for (int p = 0; p < 4; p++) begin
                if (!held[p]) begin
                    if ($urandom_range(0, 2) == 0) pv[p] = 0;
                    else begin
                        t = $urandom_range(0, 15);
                        if ($urandom_range(0, 3) != 0) begin
                            s = $urandom_range(0, 15);
                            for (int i = 0; i < NR; i++)
                                if (m_busy[(s + i) % NR]) t = m_tag[(s + i) % NR];
                        end
                        found = 0;
                        for (int r = 0; r < NR; r++) if (m_busy[r] && m_tag[r] == 4'(t)) found = 1;
                        if (found && claimed[t]) pv[p] = 0;
                        else begin
                            pv[p] = 1;
                            pt[p] = 4'(t);
                            if (found) claimed[t] = 1;
                        end
                    end
                end
            end
            dv = $urandom_range(0, 1);
            s = $urandom_range(0, 15);
            found = 0;
            for (int i = 0; i < 16; i++) begin
                bit used = 0;
                for (int r = 0; r < NR; r++) if (m_busy[r] && m_tag[r] == 4'((s + i) % 16)) used = 1;
                if (!used && !found) begin found = 1; dt = 4'((s + i) % 16); end
            end
            if (!found) dv = 0;
            da = 4'($urandom_range(0, 15));
            step();
            checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, o_ready, e_ready); end
            checks++; if (wbv !== m_wbv || fin !== m_fin) begin errors++; $display("FAIL rnd_wb c=%0d got v=%b f=%b want v=%b f=%b", c, wbv, fin, m_wbv, m_fin); end
            checks++; if (wba !== m_wba) begin errors++; $display("FAIL rnd_addr c=%0d got %0d want %0d", c, wba, m_wba); end
            checks++; if (busy !== m_busy_vec()) begin errors++; $display("FAIL rnd_busy c=%0d got %h want %h", c, busy, m_busy_vec()); end
            checks++; if ($countones(fin) > 1) begin errors++; $display("FAIL rnd_onehot c=%0d got %b want at most one bit", c, fin); end
            held = rst ? 4'b0 : (pv & ~e_ready);
        end
        rst = 0; dv = 0; pv = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; dv = 0; da = 0; dt = 0; pv = 0; pt = '0;
        test_reset();
        test_basic();
        test_priority();
        test_starve();
        test_stale();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_tag_match_unit.md
Name: reg_tag_match_unit

Overview:
- Tracks the in-flight producer tag of every architectural register.
- Compares the completion tags broadcast by the four execution pipes (ALU1, ALU2, load/store, branch) against that table.
- Each cycle, registers a one-hot tag_matched_*_final vector plus the writeback register address. The register-writeback mux select stage consumes these.
- Arbitrates so at most one register writeback occurs per cycle, back-pressuring losing pipes.

Parameters:
- NUM_REGS, 16, number of architectural registers tracked
- REG_ADDR_W, 4, register address width (log2 NUM_REGS)
- TAG_W, 4, producer tag width
- STARVE_LIMIT, 4, consecutive stalled cycles after which a waiting pipe is promoted to top priority

Ports:
- clk_in  input  1  clock, all state on rising edge
- reset_in  input  1  synchronous active-high reset
- dispatch_valid_in  input  1  new instruction allocates a destination register
- dispatch_rd_addr_in  input  REG_ADDR_W  destination register of the dispatched instruction
- dispatch_tag_in  input  TAG_W  tag assigned to the dispatched instruction
- pipeN_valid_in (N=1..4)  input  1  pipe N presents a completion
- pipeN_tag_in (N=1..4)  input  TAG_W  completing instruction tag
- pipeN_ready_out (N=1..4)  output  1  completion accepted this cycle
- tag_matched_with_alu_pipe1_final_out  output  1  writeback sourced from pipe 1
- tag_matched_with_alu_pipe2_final_out  output  1  writeback sourced from pipe 2
- tag_matched_with_load_store_pipe3_final_out  output  1  writeback sourced from pipe 3
- tag_matched_with_branch_pipe4_final_out  output  1  writeback sourced from pipe 4
- wb_valid_out  output  1  register writeback this cycle
- wb_rd_addr_out  output  REG_ADDR_W  register being written back
- reg_busy_out  output  NUM_REGS  per-register busy bit, for the issue stage

Behaviour:
- Interface: one clock, clk_in. reset_in is synchronous, active-high.
- Table:
  - Each register has a busy bit and a TAG_W tag.
  - Reset clears all busy bits and tags to 0.
- Match:
  - Pipe N "hits" when pipeN_valid_in=1 and some busy entry holds tag == pipeN_tag_in.
  - Matching uses table state at the start of the cycle.
  - Dispatch guarantees tags are unique among busy entries. Duplicate matches are illegal; the bench asserts against them.
- Stale completion: pipe valid with no matching busy entry (register re-dispatched since).
  - ready=1 the same cycle.
  - No writeback; completion is dropped.
- Arbitration (combinational ready):
  - Among hitting pipes, exactly one is granted per cycle.
  - Base priority is pipe1 > pipe2 > pipe3 > pipe4.
  - A pipe whose starve counter has reached STARVE_LIMIT overrides base priority. If several are starved, base order applies among them.
- Ready rules:
  - pipeN_ready_out=1 for the granted pipe, for stale completions, and when pipeN_valid_in=0.
  - pipeN_ready_out=0 for a hitting, non-granted pipe. That pipe must hold valid and tag stable until ready.
- Starve counters:
  - Per pipe, 3-bit, saturating at STARVE_LIMIT.
  - Increment on hit without grant.
  - Clear on grant, on valid=0, and on reset.
- Output stage (1-cycle latency from grant):
  - Next edge: wb_valid_out=1, wb_rd_addr_out = matched register, one-hot final output for the granted pipe.
  - Same edge: the matched entry's busy bit is cleared.
  - No grant: wb_valid_out=0, all four final outputs 0, wb_rd_addr_out holds its previous value.
  - At most one final output is high in any cycle.
- Dispatch:
  - On dispatch_valid_in, the entry is set to busy with dispatch_tag_in at the next edge.
  - Same-cycle dispatch and grant to the same register: writeback still issues, and dispatch wins the table, so busy stays 1 with the new tag.
  - Dispatch to an already-busy register overwrites the tag (WAW); the old tag's completion becomes stale.
- Reset:
  - All outputs are 0 during and after reset until the first grant; all pipeN_ready_out=0 while reset_in=1.
  - Reset mid-operation discards pending completions and starve counts.
- reg_busy_out reflects registered table state (post-edge).

Test Plan:
- Dispatch r3/tag5, then pipe2 valid tag5 -> pipe2_ready=1 that cycle; next cycle wb_valid=1, wb_rd_addr=3, only pipe2_final=1; reg_busy[3]=0.
- r1/tag1 and r2/tag2 busy, pipe1 tag1 and pipe4 tag2 valid same cycle -> pipe1 granted, pipe4_ready=0; next cycle pipe4 granted, wb_rd_addr=2, branch_final=1.
- Pipe1 continuously hitting fresh tags while pipe3 waits -> after 4 stalled cycles pipe3 granted (load_store_final=1), pipe1_ready=0 that cycle.
- Dispatch r7/tag9 then r7/tag10, pipe3 completes tag9 -> ready=1, wb_valid=0; pipe1 completes tag10 -> wb r7, busy[7] cleared.
- Same cycle: grant for r4/tag6 and dispatch r4/tag11 -> wb_rd_addr=4, reg_busy[4]=1 with tag 11.
- Reset asserted with pipe2 stalled -> all ready=0, outputs 0, reg_busy all 0 after edge; post-reset completions are stale.
